rx_lane_arbiter: RTL and testbench

Merges NUM_LANES independent serial-receiver packet streams into the single FIFO write port on the aclk domain. Lanes are served round-robin, one packet per grant. Each accepted packet is tagged with its source lane and counted. Sits between the per-lane receivers and the capture FIFO; lanes can be enabled or disabled at runtime by configuration.

---
 rtl/rx_lane_arbiter.sv | 117 +++++++++++
 tb/tb_rx_lane_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rx_lane_arbiter.sv
// Round-robin merge of NUM_LANES receiver packet streams into one FIFO write port.
// A single holding register tags each packet with its source lane. Drain and refill can
// happen in the same cycle, so the port sustains one packet per cycle.

module rx_lane_arbiter_lane (
  input  logic valid,
  input  logic enable,
  input  logic hit,
  input  logic load,
  input  logic areset,
  output logic qual,
  output logic ready
);
  assign qual  = valid & enable;
  // Forced low during reset so no lane sees an accept before the first edge.
  assign ready = hit & load & ~areset;
endmodule

module rx_lane_arbiter #(
  parameter int NUM_LANES     = 4,
  parameter int packet_length = 32,
  parameter int LANE_ID_W     = 2
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [NUM_LANES*packet_length-1:0] lane_data,
  input  logic [NUM_LANES-1:0]               lane_valid,
  output logic [NUM_LANES-1:0]               lane_ready,
  input  logic [NUM_LANES-1:0]               lane_enable,
  output logic [packet_length-1:0]           fifo_data,
  output logic [LANE_ID_W-1:0]               fifo_lane,
  output logic                               fifo_valid,
  input  logic                               fifo_ready,
  output logic [15:0]                        pkt_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [packet_length-1:0] data;
    logic [LANE_ID_W-1:0]     lane;
  } hold_t;

  state_t                                   state_q, state_d;
  hold_t                                    hold_q;
  logic [LANE_ID_W-1:0]                     last_grant;
  logic [LANE_ID_W-1:0]                     sel;
  logic                                     found;
  logic                                     load;
  logic                                     grant;
  logic [NUM_LANES-1:0]                     qual;
  logic [NUM_LANES-1:0][packet_length-1:0]  lane_word;

  assign lane_word = lane_data;
  assign load      = (state_q == EMPTY) | fifo_ready;
  assign grant     = |lane_ready;

  // Rotating search starting just after the last granted lane.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int off = 1; off <= NUM_LANES; off++) begin
      if (!found && qual[(int'(last_grant) + off) % NUM_LANES]) begin
        found = 1'b1;
        sel   = LANE_ID_W'((int'(last_grant) + off) % NUM_LANES);
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rx_lane_arbiter_lane u_lane (
      .valid  (lane_valid[i]),
      .enable (lane_enable[i]),
      .hit    (found && (sel == LANE_ID_W'(i))),
      .load   (load),
      .areset (areset),
      .qual   (qual[i]),
      .ready  (lane_ready[i])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (fifo_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // A grant overwrites the entry even while it drains, giving back-to-back transfers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hold_q     <= '0;
      last_grant <= LANE_ID_W'(NUM_LANES - 1);
    end else if (grant) begin
      hold_q.data <= lane_word[sel];
      hold_q.lane <= sel;
      last_grant  <= sel;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                       pkt_count <= '0;
    else if (fifo_valid && fifo_ready) pkt_count <= pkt_count + 16'd1;
  end

  assign fifo_valid = (state_q == FULL);
  assign fifo_data  = hold_q.data;
  assign fifo_lane  = hold_q.lane;

endmodule

// File: tb/tb_rx_lane_arbiter.sv
// Directed bench for rx_lane_arbiter: a per-cycle vector table for round-robin, masking
// and sparse traffic, plus hand sequences for reset, backpressure, count wrap and mid-run reset.
`timescale 1ns/1ps

module tb_rx_lane_arbiter;
  localparam int NL = 4;
  localparam int PW = 32;
  localparam int IW = 2;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NL*PW-1:0]  lane_data;
  logic [NL-1:0]     lane_valid, lane_ready, lane_enable;
  logic [PW-1:0]     fifo_data;
  logic [IW-1:0]     fifo_lane;
  logic              fifo_valid, fifo_ready;
  logic [15:0]       pkt_count;

  int checks = 0;
  int failures = 0;

  rx_lane_arbiter #(.NUM_LANES(NL), .packet_length(PW), .LANE_ID_W(IW)) dut (
    .aclk(aclk), .areset(areset), .lane_data(lane_data), .lane_valid(lane_valid),
    .lane_ready(lane_ready), .lane_enable(lane_enable), .fifo_data(fifo_data),
    .fifo_lane(fifo_lane), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .pkt_count(pkt_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [NL-1:0] lv;
    logic [NL-1:0] en;
    logic          fr;
    logic [NL-1:0] rdy;
    logic          fv;
    logic [IW-1:0] ln;
    logic [15:0]   cnt;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [3:0] lv, logic [3:0] en, logic fr, logic [3:0] rdy,
                              logic fv, logic [1:0] ln, logic [15:0] cnt);
    vec_t v;
    v.lv = lv; v.en = en; v.fr = fr; v.rdy = rdy; v.fv = fv; v.ln = ln; v.cnt = cnt;
    return v;
  endfunction

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic step(input vec_t v, input int idx);
    logic [31:0] exp_d;
    lane_valid = v.lv; lane_enable = v.en; fifo_ready = v.fr;
    #1;
    check($sformatf("row%0d lane_ready", idx), 32'(lane_ready), 32'(v.rdy));
    @(posedge aclk); #1;
    check($sformatf("row%0d fifo_valid", idx), 32'(fifo_valid), 32'(v.fv));
    check($sformatf("row%0d fifo_lane", idx), 32'(fifo_lane), 32'(v.ln));
    check($sformatf("row%0d pkt_count", idx), 32'(pkt_count), 32'(v.cnt));
    if (v.fv) begin
      exp_d = 32'hA000_0000 + 32'(v.ln);
      check($sformatf("row%0d fifo_data", idx), fifo_data, exp_d);
    end
    @(negedge aclk);
  endtask

  initial begin
    areset = 1'b1;
    lane_valid = 4'hF; lane_enable = 4'hF; fifo_ready = 1'b1;
    for (int i = 0; i < NL; i++) lane_data[i*PW +: PW] = 32'hA000_0000 + 32'(i);

    // round robin, then the 8th packet drains
    tbl[0]  = mk(4'hF, 4'hF, 1, 4'b0001, 1, 0, 0);
    tbl[1]  = mk(4'hF, 4'hF, 1, 4'b0010, 1, 1, 1);
    tbl[2]  = mk(4'hF, 4'hF, 1, 4'b0100, 1, 2, 2);
    tbl[3]  = mk(4'hF, 4'hF, 1, 4'b1000, 1, 3, 3);
    tbl[4]  = mk(4'hF, 4'hF, 1, 4'b0001, 1, 0, 4);
    tbl[5]  = mk(4'hF, 4'hF, 1, 4'b0010, 1, 1, 5);
    tbl[6]  = mk(4'hF, 4'hF, 1, 4'b0100, 1, 2, 6);
    tbl[7]  = mk(4'hF, 4'hF, 1, 4'b1000, 1, 3, 7);
    tbl[8]  = mk(4'h0, 4'hF, 1, 4'b0000, 0, 3, 8);
    // enable mask 1010, then 0001
    tbl[9]  = mk(4'hF, 4'hA, 1, 4'b0010, 1, 1, 8);
    tbl[10] = mk(4'hF, 4'hA, 1, 4'b1000, 1, 3, 9);
    tbl[11] = mk(4'hF, 4'hA, 1, 4'b0010, 1, 1, 10);
    tbl[12] = mk(4'hF, 4'hA, 1, 4'b1000, 1, 3, 11);
    tbl[13] = mk(4'hF, 4'h1, 1, 4'b0001, 1, 0, 12);
    tbl[14] = mk(4'h0, 4'hF, 1, 4'b0000, 0, 0, 13);
    // sparse: lane 3, then lane 1 right after
    tbl[15] = mk(4'h8, 4'hF, 1, 4'b1000, 1, 3, 13);
    tbl[16] = mk(4'h2, 4'hF, 1, 4'b0010, 1, 1, 14);
    tbl[17] = mk(4'h0, 4'hF, 1, 4'b0000, 0, 1, 15);

    // reset with all lanes valid and the FIFO ready
    @(posedge aclk); @(negedge aclk);
    check("rst lane_ready", 32'(lane_ready), 32'h0);
    check("rst fifo_valid", 32'(fifo_valid), 32'h0);
    check("rst pkt_count", 32'(pkt_count), 32'h0);
    check("rst fifo_data", fifo_data, 32'h0);
    areset = 1'b0;

    for (int r = 0; r < 18; r++) step(tbl[r], r);

    // backpressure: lane 2 sends DEADBEEF, FIFO stalls 5 cycles with all lanes valid
    lane_data[2*PW +: PW] = 32'hDEAD_BEEF;
    lane_valid = 4'b0100; lane_enable = 4'hF; fifo_ready = 1'b0;
    #1 check("bp grant", 32'(lane_ready), 32'b0100);
    @(posedge aclk); #1;
    check("bp load data", fifo_data, 32'hDEAD_BEEF);
    check("bp load lane", 32'(fifo_lane), 32'd2);
    @(negedge aclk);
    lane_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1 check($sformatf("bp%0d lane_ready", c), 32'(lane_ready), 32'h0);
      @(posedge aclk); #1;
      check($sformatf("bp%0d fifo_valid", c), 32'(fifo_valid), 32'h1);
      check($sformatf("bp%0d fifo_data", c), fifo_data, 32'hDEAD_BEEF);
      check($sformatf("bp%0d fifo_lane", c), 32'(fifo_lane), 32'd2);
      check($sformatf("bp%0d pkt_count", c), 32'(pkt_count), 32'd15);
      @(negedge aclk);
    end
    lane_valid = 4'h0; fifo_ready = 1'b1;
    @(posedge aclk); #1;
    check("bp drain valid", 32'(fifo_valid), 32'h0);
    check("bp drain count", 32'(pkt_count), 32'd16);
    @(negedge aclk);
    lane_data[2*PW +: PW] = 32'hA000_0002;

    // count wrap: first cycle only grants, each later cycle delivers one packet
    lane_valid = 4'hF; fifo_ready = 1'b1;
    repeat (65520) @(negedge aclk);
    check("wrap ffff", 32'(pkt_count), 32'hFFFF);
    @(negedge aclk);
    check("wrap zero", 32'(pkt_count), 32'h0);

    // stall with a packet held, then reset mid-cycle
    fifo_ready = 1'b0;
    @(posedge aclk); #1;
    check("hold valid", 32'(fifo_valid), 32'h1);
    check("hold count", 32'(pkt_count), 32'h0);
    areset = 1'b1;
    #1;
    check("midrst fifo_valid", 32'(fifo_valid), 32'h0);
    check("midrst lane_ready", 32'(lane_ready), 32'h0);
    check("midrst pkt_count", 32'(pkt_count), 32'h0);
    check("midrst fifo_lane", 32'(fifo_lane), 32'h0);
    @(negedge aclk);
    areset = 1'b0; lane_valid = 4'h0; fifo_ready = 1'b1;
    @(negedge aclk);
    check("post-rst valid", 32'(fifo_valid), 32'h0);
    check("post-rst count", 32'(pkt_count), 32'h0);
    lane_valid = 4'hF;
    #1 check("post-rst grant", 32'(lane_ready), 32'b0001);
    @(posedge aclk); #1;
    check("post-rst lane", 32'(fifo_lane), 32'd0);
    check("post-rst fv", 32'(fifo_valid), 32'h1);
    check("post-rst cnt", 32'(pkt_count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
